// File: rtl/imu_rd_seq.sv
// IMU read sequencer: waits out the gyro power-up time, writes three
// configuration registers over an SPI monarch, then on each data-ready
// interrupt reads the yaw-rate low and high bytes and presents a 16-bit
// sample with a one-cycle valid pulse.
module imu_rd_seq #(
  parameter int unsigned TMR_BITS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] inert_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [15:0] yaw_rt,
  output logic        vld,
  output logic        init_done
);

  // Each transaction has an issue state (the wrt cycle, where done is
  // still stale) followed by a wait state that watches done.
  localparam logic [3:0] StWaitTmr = 4'd0;
  localparam logic [3:0] StInit1   = 4'd1;
  localparam logic [3:0] StInit1W  = 4'd2;
  localparam logic [3:0] StInit2   = 4'd3;
  localparam logic [3:0] StInit2W  = 4'd4;
  localparam logic [3:0] StInit3   = 4'd5;
  localparam logic [3:0] StInit3W  = 4'd6;
  localparam logic [3:0] StIdle    = 4'd7;
  localparam logic [3:0] StRdL     = 4'd8;
  localparam logic [3:0] StRdLW    = 4'd9;
  localparam logic [3:0] StRdH     = 4'd10;
  localparam logic [3:0] StRdHW    = 4'd11;

  localparam logic [15:0] CmdInit1 = 16'h0D02;
  localparam logic [15:0] CmdInit2 = 16'h1160;
  localparam logic [15:0] CmdInit3 = 16'h1440;
  localparam logic [15:0] CmdRdL   = 16'hA600;
  localparam logic [15:0] CmdRdH   = 16'hA700;

  // wrt is registered, so it is requested one count early; it is then
  // high in the same cycle the counter reads all-ones.
  localparam logic [TMR_BITS-1:0] TmrPre = {TMR_BITS{1'b1}} - TMR_BITS'(1);

  logic [3:0]          r_state;
  logic [TMR_BITS-1:0] r_tmr;
  logic                r_int_ff1;
  logic                r_int_ff2;
  logic                r_wrt;
  logic [15:0]         r_cmd;
  logic [7:0]          r_low;
  logic [15:0]         r_yaw;
  logic                r_vld;
  logic                r_init_done;

  logic [3:0]          w_state;
  logic [TMR_BITS-1:0] w_tmr;
  logic                w_wrt;
  logic [15:0]         w_cmd;
  logic [7:0]          w_low;
  logic [15:0]         w_yaw;
  logic                w_vld;
  logic                w_init_done;

  // Next-state and registered-output decode.
  always_comb begin
    w_state     = r_state;
    w_tmr       = r_tmr;
    w_wrt       = 1'b0;
    w_cmd       = r_cmd;
    w_low       = r_low;
    w_yaw       = r_yaw;
    w_vld       = 1'b0;
    w_init_done = r_init_done;
    case (r_state)
      StWaitTmr: begin
        w_tmr = r_tmr + TMR_BITS'(1);
        if (r_tmr == TmrPre) begin
          w_wrt   = 1'b1;
          w_cmd   = CmdInit1;
          w_state = StInit1;
        end
      end
      StInit1: w_state = StInit1W;
      StInit1W: begin
        if (done) begin
          w_wrt   = 1'b1;
          w_cmd   = CmdInit2;
          w_state = StInit2;
        end
      end
      StInit2: w_state = StInit2W;
      StInit2W: begin
        if (done) begin
          w_wrt   = 1'b1;
          w_cmd   = CmdInit3;
          w_state = StInit3;
        end
      end
      StInit3: w_state = StInit3W;
      StInit3W: begin
        if (done) begin
          w_init_done = 1'b1;
          w_state     = StIdle;
        end
      end
      StIdle: begin
        if (r_int_ff2) begin
          w_wrt   = 1'b1;
          w_cmd   = CmdRdL;
          w_state = StRdL;
        end
      end
      StRdL: w_state = StRdLW;
      StRdLW: begin
        if (done) begin
          w_low   = inert_data[7:0];
          w_wrt   = 1'b1;
          w_cmd   = CmdRdH;
          w_state = StRdH;
        end
      end
      StRdH: w_state = StRdHW;
      StRdHW: begin
        if (done) begin
          // Low byte is only ever exposed together with its high byte.
          w_yaw   = {inert_data[7:0], r_low};
          w_vld   = 1'b1;
          w_state = StIdle;
        end
      end
      default: w_state = StWaitTmr;
    endcase
  end

  // State, datapath and INT synchroniser with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StWaitTmr;
      r_tmr       <= '0;
      r_int_ff1   <= 1'b0;
      r_int_ff2   <= 1'b0;
      r_wrt       <= 1'b0;
      r_cmd       <= 16'h0000;
      r_low       <= 8'h00;
      r_yaw       <= 16'h0000;
      r_vld       <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_tmr       <= w_tmr;
      r_int_ff1   <= INT;
      r_int_ff2   <= r_int_ff1;
      r_wrt       <= w_wrt;
      r_cmd       <= w_cmd;
      r_low       <= w_low;
      r_yaw       <= w_yaw;
      r_vld       <= w_vld;
      r_init_done <= w_init_done;
    end
  end

  assign wrt       = r_wrt;
  assign cmd       = r_cmd;
  assign yaw_rt    = r_yaw;
  assign vld       = r_vld;
  assign init_done = r_init_done;

endmodule

// File: doc/imu_rd_seq.md
IMU_RD_SEQ -- requirements
Module: imu_rd_seq

Interface
REQ-001 Parameter TMR_BITS, default 16, width of the power-up wait counter; the wait is 2^TMR_BITS-1 cycles.
REQ-002 Port clk, input, 1, the single clock; all flops clock on its rising edge.
REQ-003 Port rst, input, 1, synchronous active-high reset.
REQ-004 Port INT, input, 1, asynchronous data-ready interrupt from the gyro, active high.
REQ-005 Port done, input, 1, SPI monarch transaction-complete level: low from the cycle after wrt, high when the transaction ends.
REQ-006 Port inert_data, input, 16, SPI monarch read data; only bits [7:0] are meaningful and only while done is high.
REQ-007 Port wrt, output, 1, single-cycle request to the SPI monarch to start a transaction.
REQ-008 Port cmd, output, 16, SPI command word: upper byte is address (bit 15 set = read), lower byte is write data.
REQ-009 Port yaw_rt, output, 16, assembled signed yaw-rate sample {high byte, low byte}.
REQ-010 Port vld, output, 1, one-cycle pulse marking a new yaw_rt value.
REQ-011 Port init_done, output, 1, high once the sensor configuration writes have completed.

Function
REQ-012 The sequencer SHALL use a state machine with states WAIT_TMR, INIT1, INIT2, INIT3, IDLE, RD_L, RD_H, plus one wait substate per transaction (or equivalent encoding) that waits for done.
REQ-013 WAIT_TMR: a TMR_BITS-bit counter starts at 0 and increments every cycle; the cycle it reads all-ones, the sequencer SHALL pulse wrt with cmd=16'h0D02 and leave WAIT_TMR.
REQ-014 Each transaction: wrt high exactly one cycle; cmd valid in the wrt cycle and held stable until done is seen high; done is not sampled in the wrt cycle itself.
REQ-015 Init order SHALL be 16'h0D02, then 16'h1160, then 16'h1440; each wrt is issued in the cycle after the previous transaction's done is seen high.
REQ-016 After done for 16'h1440, init_done SHALL go high the next cycle and remain high until reset; the state SHALL become IDLE.
REQ-017 INT SHALL pass through two flops before use; INT_ff2 is the only INT signal used by the state machine.
REQ-018 In IDLE with INT_ff2 high, the sequencer SHALL pulse wrt with cmd=16'hA600 and enter RD_L.
REQ-019 RD_L on done high: capture inert_data[7:0] as the low byte, then pulse wrt with cmd=16'hA700 in the same cycle and enter RD_H.
REQ-020 RD_H on done high: yaw_rt <= {inert_data[7:0], low byte}; vld pulses one cycle, coincident with the yaw_rt update; return to IDLE.
REQ-021 yaw_rt SHALL hold its value between vld pulses; the low byte is never exposed alone.
REQ-022 INT is ignored outside IDLE, so an INT during init or mid-read is not queued; if INT_ff2 is still high on return to IDLE, a new read starts in that cycle.
REQ-023 Minimum spacing between vld pulses SHALL be the duration of two SPI transactions plus one cycle; there is no back-pressure on vld.
REQ-024 wrt SHALL never be asserted while a transaction is outstanding, meaning after a wrt and before done is seen high.

Reset
REQ-025 When rst is high at a clock edge, the next state SHALL be WAIT_TMR, the counter 0, wrt=0, cmd=16'h0000, yaw_rt=16'h0000, vld=0, init_done=0, and the INT flops 0.
REQ-026 A reset mid-transaction SHALL abandon the transaction with no wrt and no vld; the full init sequence then reruns.

Verification
REQ-027 TMR_BITS=4, release rst -> first wrt exactly 15 cycles after rst deasserts, cmd=16'h0D02.
REQ-028 SPI model, done 40 cycles after each wrt -> wrt with cmds 0D02, 1160, 1440 in order, each one cycle after done; init_done rises one cycle after the third done.
REQ-029 After init, INT pulse with model returning low=8'h34, high=8'h12 -> cmds A600 then A700, yaw_rt=16'h1234, exactly one vld.
REQ-030 INT held high across two reads with data 8'hFF/8'h80, then 8'h01/8'h00 -> two back-to-back reads, yaw_rt 16'h80FF then 16'h0001, two vld pulses.
REQ-031 INT asserted during INIT2 then dropped before IDLE -> no A600 command issued and no vld.
REQ-032 rst asserted in RD_H before done -> wrt and vld stay 0, yaw_rt=0, init_done=0, and the init sequence restarts from WAIT_TMR.
